// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot/load controller.
package imem_ctrl_pkg;

    localparam int unsigned DefAddrW    = 10;
    localparam int unsigned DefMemWords = 1 << DefAddrW;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StDrain = 2'd2,
        StRun   = 2'd3
    } state_e;

    // Byte address to word index; callers truncate to their memory width.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/imem_load_counter.sv
// Load-session word counter: clear+capture length, increment per write, flag the final word.
module imem_load_counter #(
    parameter int unsigned AddrW = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [AddrW:0]   len_i,
    input  logic             inc_i,
    output logic [AddrW-1:0] cnt_o,
    output logic             last_o
);

    logic [AddrW:0] cnt_q, cnt_d;
    logic [AddrW:0] len_q, len_d;

    always_comb begin
        cnt_d = cnt_q;
        len_d = len_q;
        if (load_i) begin
            cnt_d = '0;
            len_d = len_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

    assign cnt_o  = cnt_q[AddrW-1:0];
    // Full-width compare so a MEM_WORDS-long session terminates without wrapping.
    assign last_o = ((cnt_q + 1'b1) == len_q);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot/load controller: owns the instruction-memory write port, gates the core,
// and translates PC byte addresses for the fetch port.
module imem_boot_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned MEM_WORDS = DefMemWords
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              boot_go,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       pc_addr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              core_run,
    output logic              load_done,
    output logic              len_err,
    output logic              fetch_fault
);

    localparam int unsigned     CntW      = ADDR_W + 1;
    localparam logic [CntW-1:0] MemWordsC = CntW'(MEM_WORDS);

    state_e          state_q, state_d;
    logic            load_done_q, load_done_d;
    logic            len_err_q, len_err_d;
    logic            fetch_fault_q, fetch_fault_d;
    logic            start_load;
    logic            cnt_last;
    logic            fault_now;
    logic [CntW-1:0] len_clip;
    logic [31:0]     word_idx;

    assign ld_ready    = (state_q == StLoad);
    assign core_run    = (state_q == StRun);
    assign mem_we      = ld_valid & ld_ready;
    assign mem_wdata   = ld_data;
    assign load_done   = load_done_q;
    assign len_err     = len_err_q;
    assign fetch_fault = fetch_fault_q;

    assign word_idx  = word_index(pc_addr);
    assign mem_raddr = word_idx[ADDR_W-1:0];
    assign fault_now = (pc_addr[1:0] != 2'b00) || ((word_idx >> ADDR_W) != 32'd0);
    assign len_clip  = (load_len > MemWordsC) ? MemWordsC : load_len;

    always_comb begin
        state_d       = state_q;
        start_load    = 1'b0;
        len_err_d     = len_err_q;
        fetch_fault_d = fetch_fault_q;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    start_load = 1'b1;
                end else if (boot_go) begin
                    state_d = StRun;
                end
            end
            StLoad: begin
                if (mem_we && cnt_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StRun;
            StRun: begin
                if (load_start) begin
                    start_load = 1'b1;
                end else if (fault_now) begin
                    fetch_fault_d = 1'b1;
                end
            end
        endcase
        if (start_load) begin
            len_err_d     = (load_len > MemWordsC);
            fetch_fault_d = 1'b0;
            state_d       = (load_len == '0) ? StDrain : StLoad;
        end
        load_done_d = (state_d == StRun) && (state_q != StRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            load_done_q   <= 1'b0;
            len_err_q     <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_done_q   <= load_done_d;
            len_err_q     <= len_err_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    imem_load_counter #(
        .AddrW (ADDR_W)
    ) u_load_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (start_load),
        .len_i  (len_clip),
        .inc_i  (mem_we),
        .cnt_o  (mem_waddr),
        .last_o (cnt_last)
    );

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: write scoreboard, fetch vector table,
// and hand-written boot/load/reset sequences.
module tb_imem_boot_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned MW = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start, boot_go, ld_valid;
    logic [AW:0]   load_len;
    logic [31:0]   ld_data, pc_addr;
    logic          ld_ready, mem_we, core_run, load_done, len_err, fetch_fault;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [31:0]   mem_wdata;

    int checks   = 0;
    int failures = 0;
    int n_writes = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;
    wr_t sb_q[$];

    typedef struct {
        logic [31:0]   pc;
        logic [AW-1:0] raddr;
        logic          fault;
    } fetch_vec_t;
    fetch_vec_t vecs[7];

    always #5 clk = ~clk;

    imem_boot_ctrl #(
        .ADDR_W    (AW),
        .MEM_WORDS (MW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_len    (load_len),
        .boot_go     (boot_go),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .pc_addr     (pc_addr),
        .mem_raddr   (mem_raddr),
        .core_run    (core_run),
        .load_done   (load_done),
        .len_err     (len_err),
        .fetch_fault (fetch_fault)
    );

    // Every observed write must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write",
                         mem_waddr, mem_wdata);
            end else begin
                wr_t exp_wr;
                exp_wr = sb_q.pop_front();
                n_writes++;
                if (mem_waddr !== exp_wr.addr || mem_wdata !== exp_wr.data) begin
                    failures++;
                    $display("FAIL write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                             mem_waddr, mem_wdata, exp_wr.addr, exp_wr.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d);
        int budget;
        budget   = 50;
        ld_valid = 1'b1;
        ld_data  = d;
        #1;
        while (!ld_ready && budget > 0) begin
            tick();
            #1;
            budget--;
        end
        if (!ld_ready) begin
            checks++;
            failures++;
            $display("FAIL ld_ready_timeout: got ld_ready=0 expected 1 for data %0h", d);
        end
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic load_words(input int n, input logic [31:0] base, input bit gaps);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back({AW'(i), base + 32'(i)});
        end
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) tick();
            send_word(base + 32'(i));
        end
    endtask

    // Called one cycle after the final accept: DRAIN now, RUN + load_done next cycle.
    task automatic check_drain_run(input string tag);
        #1;
        check({tag, "_drain_ready"}, ld_ready, 0);
        check({tag, "_drain_run"}, core_run, 0);
        tick();
        #1;
        check({tag, "_run"}, core_run, 1);
        check({tag, "_load_done"}, load_done, 1);
        tick();
        #1;
        check({tag, "_load_done_pulse"}, load_done, 0);
        check({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    task automatic pulse_load(input logic [AW:0] len);
        tick();
        load_len   = len;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        int base_writes;
        vecs[0] = '{32'h0000_0000, 10'h000, 1'b0};
        vecs[1] = '{32'h0000_0004, 10'h001, 1'b0};
        vecs[2] = '{32'h0000_0FFC, 10'h3FF, 1'b0};
        vecs[3] = '{32'h0000_0400, 10'h100, 1'b0};
        vecs[4] = '{32'h0000_0006, 10'h001, 1'b1};
        vecs[5] = '{32'h0000_0008, 10'h002, 1'b1};
        vecs[6] = '{32'h0000_1000, 10'h000, 1'b1};

        rst_n = 1'b0; load_start = 1'b0; boot_go = 1'b0; ld_valid = 1'b0;
        load_len = '0; ld_data = '0; pc_addr = '0;
        #3;
        check("rst_ld_ready", ld_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_waddr", mem_waddr, 0);
        check("rst_mem_raddr", mem_raddr, 0);
        check("rst_core_run", core_run, 0);
        check("rst_load_done", load_done, 0);
        check("rst_len_err", len_err, 0);
        check("rst_fetch_fault", fetch_fault, 0);
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        check("idle_core_run", core_run, 0);

        // Boot preloaded image.
        tick();
        boot_go = 1'b1;
        #1;
        check("boot_pre_run", core_run, 0);
        tick();
        boot_go = 1'b0;
        #1;
        check("boot_run", core_run, 1);
        check("boot_load_done", load_done, 1);
        tick();
        #1;
        check("boot_load_done_pulse", load_done, 0);

        // Fetch translation and sticky fault.
        foreach (vecs[i]) begin
            tick();
            pc_addr = vecs[i].pc;
            #1;
            check($sformatf("raddr_%0d", i), mem_raddr, vecs[i].raddr);
            tick();
            #1;
            check($sformatf("fault_%0d", i), fetch_fault, vecs[i].fault);
        end
        pc_addr = '0;

        // 4-word load with valid gaps from RUN; clears the fault.
        pulse_load(4);
        #1;
        check("l4_core_run", core_run, 0);
        check("l4_ld_ready", ld_ready, 1);
        check("l4_fault_clr", fetch_fault, 0);
        check("l4_len_err", len_err, 0);
        load_words(4, 32'hA0, 1'b1);
        check_drain_run("l4");

        // Zero-length load with ld_valid held high: no writes.
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD_BEEF;
        pulse_load(0);
        check_drain_run("l0");
        ld_valid = 1'b0;

        // Over-length load clips to MEM_WORDS.
        base_writes = n_writes;
        pulse_load(11'(MW + 5));
        #1;
        check("lbig_len_err", len_err, 1);
        check("lbig_ld_ready", ld_ready, 1);
        load_words(MW, 32'hC000_0000, 1'b0);
        ld_valid = 1'b1;
        ld_data  = 32'hBAD0_0000;
        check_drain_run("lbig");
        ld_valid = 1'b0;
        check("lbig_len_err_hold", len_err, 1);
        check("lbig_write_count", n_writes - base_writes, MW);

        // Reset in the middle of an 8-word load.
        pulse_load(8);
        #1;
        check("l8_len_err_clr", len_err, 0);
        load_words(2, 32'hB0, 1'b0);
        rst_n    = 1'b0;
        ld_valid = 1'b1;
        #1;
        check("mrst_ld_ready", ld_ready, 0);
        check("mrst_mem_we", mem_we, 0);
        check("mrst_mem_waddr", mem_waddr, 0);
        check("mrst_core_run", core_run, 0);
        check("mrst_load_done", load_done, 0);
        check("mrst_len_err", len_err, 0);
        ld_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check("mrst_idle_run", core_run, 0);
            check("mrst_idle_done", load_done, 0);
            check("mrst_idle_ready", ld_ready, 0);
        end

        // Simultaneous load_start and boot_go: load wins.
        tick();
        load_len   = 2;
        load_start = 1'b1;
        boot_go    = 1'b1;
        tick();
        load_start = 1'b0;
        boot_go    = 1'b0;
        #1;
        check("both_ld_ready", ld_ready, 1);
        check("both_core_run", core_run, 0);
        check("both_load_done", load_done, 0);
        load_words(2, 32'hD0, 1'b0);
        check_drain_run("both");

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot/load controller that owns the write side of the instruction memory and gates the single-cycle core around it. After reset it holds the core, optionally streams a program into instruction memory over a valid/ready port, then releases the core. While the core runs, it translates PC byte addresses to word addresses for the fetch port and flags faulting fetches.

## Interface
Parameters:
- ADDR_W, 10: instruction-memory word-address width.
- MEM_WORDS, 1024: memory depth in words. Must equal 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle pulse that begins a load session.
- load_len  in  ADDR_W+1  number of words to load; sampled on load_start.
- boot_go  in  1  pulse that runs the preloaded image without loading.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader instruction word.
- ld_ready  out  1  controller accepts the word this cycle.
- mem_we  out  1  instruction-memory write enable.
- mem_waddr  out  ADDR_W  write word address.
- mem_wdata  out  32  write data.
- pc_addr  in  32  core PC, byte address.
- mem_raddr  out  ADDR_W  read word address = pc_addr[ADDR_W+1:2].
- core_run  out  1  1 = core may advance its PC; 0 = core holds its PC.
- load_done  out  1  one-cycle pulse on entry to RUN.
- len_err  out  1  sticky: load_len exceeded MEM_WORDS and was clipped.
- fetch_fault  out  1  sticky: misaligned or out-of-range fetch seen in RUN.

## Operation
- States: IDLE, LOAD, DRAIN, RUN. Reset state is IDLE.
- IDLE: core_run=0, ld_ready=0.
  - load_start -> LOAD.
  - boot_go -> RUN.
  - If both arrive in the same cycle, load_start wins.
- LOAD:
  - ld_ready=1. Each handshake (ld_valid & ld_ready) writes ld_data at word address cnt, then cnt increments.
  - On accepting word number len-1 -> DRAIN.
  - load_start and boot_go are ignored while in LOAD.
- DRAIN: one cycle with no writes -> RUN. Guarantees the final write has landed before the first fetch.
- RUN:
  - core_run=1.
  - load_start -> LOAD: core_run drops, cnt=0, both sticky flags clear.
  - boot_go is ignored.
- Length handling on load_start:
  - cnt=0 and len=min(load_len, MEM_WORDS).
  - If load_len > MEM_WORDS, set len_err.
  - If load_len==0, go to DRAIN directly with no writes.
- Write port: mem_we = ld_valid & ld_ready (combinational), mem_waddr=cnt, mem_wdata=ld_data.
- fetch_fault is set in RUN when pc_addr[1:0]!=0 or pc_addr[31:ADDR_W+2]!=0. It holds until the next load_start or reset. mem_raddr is still driven from truncated bits.
- Reset mid-load: return to IDLE, cnt=0, no load_done. Memory contents stay partial.

## Timing
- All outputs reset to 0: ld_ready, mem_we, mem_waddr, mem_wdata, mem_raddr (= pc_addr bits), core_run, load_done, len_err, fetch_fault.
- Write latency: a word accepted in cycle N is in memory at the rising edge ending cycle N.
- Last accept in cycle N: DRAIN in N+1; RUN and load_done in N+2; core_run=1 from N+2.
- boot_go in IDLE at cycle N: RUN, core_run and load_done in N+1.
- load_start in RUN at cycle N: core_run=0 and ld_ready=1 in N+1.
- ld_ready and core_run are decoded from the registered state only, with no input-to-output combinational path. mem_we and mem_raddr are combinational.
- Counter width is ADDR_W+1. cnt never wraps, because the session ends at len ≤ MEM_WORDS.

## Structure
- Package imem_ctrl_pkg holds:
  - the state encoding (IDLE=0, LOAD=1, DRAIN=2, RUN=3);
  - the default ADDR_W/MEM_WORDS constants;
  - the address-translation function for the word index.
- One natural sub-module, imem_load_counter: load/clear/increment plus terminal-count compare against len.

## Test plan
- Reset, then boot_go -> core_run=1 and load_done pulse one cycle later; no mem_we ever asserted.
- load_start with load_len=4, words 0xA0..0xA3 with ld_valid gaps -> writes at addresses 0..3; DRAIN; core_run=1 exactly 2 cycles after the 4th accept.
- load_len=0 -> no writes; RUN 2 cycles after load_start.
- load_len=MEM_WORDS+5 -> len_err=1, exactly MEM_WORDS writes, last at address MEM_WORDS-1, no wrap.
- In RUN, pc_addr=0x6 -> fetch_fault=1 with mem_raddr=1; pc_addr=0x8 keeps fault high; a new load_start clears it.
- rst_n low after 2 of 8 words -> IDLE, outputs 0, no load_done; simultaneous load_start+boot_go in IDLE -> LOAD.
